// File: rtl/eight_queen_solver.sv
// rtl/eight_queen_solver.sv - backtracking eight-queens search engine with valid/ready solution port

// Pairwise attack test between a candidate square and one placed queen.
// The caller guarantees the rows differ, so only column and diagonal hits matter.
module safety_check (
  input  logic [2:0] i_r_ch,
  input  logic [2:0] i_c_ch,
  input  logic [2:0] i_r2,
  input  logic [2:0] i_c2,
  output logic       o_threat
);

  logic [2:0] w_dr;
  logic [2:0] w_dc;

  // Absolute row/column distances; equal distances mean a shared diagonal.
  always_comb begin
    w_dr     = (i_r_ch >= i_r2) ? (i_r_ch - i_r2) : (i_r2 - i_r_ch);
    w_dc     = (i_c_ch >= i_c2) ? (i_c_ch - i_c2) : (i_c2 - i_c_ch);
    o_threat = (i_c_ch == i_c2) || (w_dr == w_dc);
  end

endmodule

module eight_queen_solver #(
  parameter bit FIRST_ONLY = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_sol_valid,
  input  logic        i_sol_ready,
  output logic [23:0] o_sol_cols,
  output logic [6:0]  o_sol_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PLACE,
    S_ADVANCE,
    S_BACKTRACK,
    S_EMIT,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_cols [0:7];
  logic [2:0] w_cols_nxt [0:7];
  logic [2:0] r_row;
  logic [2:0] w_row_nxt;
  logic [2:0] r_col;
  logic [2:0] w_col_nxt;
  logic [2:0] r_k;
  logic [2:0] w_k_nxt;
  logic [6:0] r_count;
  logic [6:0] w_count_nxt;
  logic [2:0] w_row_m1;
  logic       w_threat;

  assign w_row_m1 = r_row - 3'd1;

  // Candidate (r, c) is compared against the queen already placed in scan row k.
  safety_check u_safety_check (
    .i_r_ch   (r_row),
    .i_c_ch   (r_col),
    .i_r2     (r_k),
    .i_c2     (r_cols[r_k]),
    .o_threat (w_threat)
  );

  // Next-state and datapath updates for the search walk.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_k_nxt     = r_k;
    w_count_nxt = r_count;
    for (int i = 0; i < 8; i++) begin
      w_cols_nxt[i] = r_cols[i];
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_row_nxt   = 3'd0;
          w_col_nxt   = 3'd0;
          w_k_nxt     = 3'd0;
          w_count_nxt = 7'd0;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_k == r_row) begin
          w_state_nxt = S_PLACE;
        end else if (w_threat) begin
          w_state_nxt = S_ADVANCE;
        end else begin
          w_k_nxt = r_k + 3'd1;
        end
      end
      S_PLACE: begin
        w_cols_nxt[r_row] = r_col;
        if (r_row == 3'd7) begin
          w_state_nxt = S_EMIT;
        end else begin
          w_row_nxt   = r_row + 3'd1;
          w_col_nxt   = 3'd0;
          w_k_nxt     = 3'd0;
          w_state_nxt = S_CHECK;
        end
      end
      S_ADVANCE: begin
        if (r_col == 3'd7) begin
          w_state_nxt = S_BACKTRACK;
        end else begin
          w_col_nxt   = r_col + 3'd1;
          w_k_nxt     = 3'd0;
          w_state_nxt = S_CHECK;
        end
      end
      S_BACKTRACK: begin
        if (r_row == 3'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_row_nxt   = w_row_m1;
          w_col_nxt   = r_cols[w_row_m1];
          w_state_nxt = S_ADVANCE;
        end
      end
      S_EMIT: begin
        // Row 7 and its column are still loaded, so ADVANCE resumes the walk.
        if (i_sol_ready) begin
          w_count_nxt = r_count + 7'd1;
          w_state_nxt = FIRST_ONLY ? S_DONE : S_ADVANCE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_row   <= 3'd0;
      r_col   <= 3'd0;
      r_k     <= 3'd0;
      r_count <= 7'd0;
      for (int i = 0; i < 8; i++) begin
        r_cols[i] <= 3'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_k     <= w_k_nxt;
      r_count <= w_count_nxt;
      for (int i = 0; i < 8; i++) begin
        r_cols[i] <= w_cols_nxt[i];
      end
    end
  end

  // Status and solution outputs decoded from registered state.
  always_comb begin
    o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    o_done      = (r_state == S_DONE);
    o_sol_valid = (r_state == S_EMIT);
    o_sol_count = r_count;
    o_sol_cols  = 24'd0;
    for (int i = 0; i < 8; i++) begin
      o_sol_cols[3*i +: 3] = r_cols[i];
    end
  end

endmodule

// File: tb/tb_eight_queen_solver.sv
// tb/tb_eight_queen_solver.sv - scoreboard bench for eight_queen_solver

module tb_eight_queen_solver;

  logic        clk;
  logic        rst;
  logic        start0, ready0, busy0, done0, valid0;
  logic [23:0] cols0;
  logic [6:0]  count0;
  logic        start1, ready1, busy1, done1, valid1;
  logic [23:0] cols1;
  logic [6:0]  count1;

  int checks;
  int errors;
  logic [23:0] exp_q [$];
  logic [23:0] model [$];

  eight_queen_solver #(.FIRST_ONLY(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_busy(busy0), .o_done(done0),
    .o_sol_valid(valid0), .i_sol_ready(ready0), .o_sol_cols(cols0), .o_sol_count(count0)
  );

  eight_queen_solver #(.FIRST_ONLY(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
    .o_sol_valid(valid1), .i_sol_ready(ready1), .o_sol_cols(cols1), .o_sol_count(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent software check: no two queens share a column or diagonal.
  function automatic logic board_ok(input logic [23:0] b);
    int ci, cj, d;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        ci = int'(b[3*i +: 3]);
        cj = int'(b[3*j +: 3]);
        d  = (ci > cj) ? ci - cj : cj - ci;
        if (ci == cj || d == j - i) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Lexicographic enumeration of all solutions, row 0 most significant.
  task automatic build_model();
    int col [0:7];
    int row;
    logic ok;
    logic [23:0] b;
    model.delete();
    row = 0;
    col[0] = 0;
    while (row >= 0) begin
      if (col[row] > 7) begin
        row--;
        if (row >= 0) col[row]++;
      end else begin
        ok = 1'b1;
        for (int j = 0; j < row; j++) begin
          if (col[j] == col[row] || col[row] - col[j] == row - j || col[j] - col[row] == row - j)
            ok = 1'b0;
        end
        if (!ok) begin
          col[row]++;
        end else if (row == 7) begin
          b = 24'd0;
          for (int i = 0; i < 8; i++) b[3*i +: 3] = col[i][2:0];
          model.push_back(b);
          col[row]++;
        end else begin
          row++;
          col[row] = 0;
        end
      end
    end
  endtask

  task automatic check_zero0(input string tag);
    check({tag, "_busy0"},  {31'd0, busy0},  32'd0);
    check({tag, "_done0"},  {31'd0, done0},  32'd0);
    check({tag, "_valid0"}, {31'd0, valid0}, 32'd0);
    check({tag, "_cols0"},  {8'd0, cols0},   32'd0);
    check({tag, "_count0"}, {25'd0, count0}, 32'd0);
  endtask

  initial begin
    int n;
    int cyc;
    logic [23:0] got;
    logic [23:0] want;
    logic [23:0] last;

    checks = 0;
    errors = 0;
    start0 = 1'b0; ready0 = 1'b1;
    start1 = 1'b0; ready1 = 1'b0;

    // Reset with start held high: start must be ignored.
    rst = 1'b1;
    #2;
    start0 = 1'b1;
    start1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero0("rst_hold");
    check("rst_hold_busy1", {31'd0, busy1}, 32'd0);
    start0 = 1'b0;
    start1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_zero0("reset");
    check("reset_busy1", {31'd0, busy1}, 32'd0);
    check("reset_count1", {25'd0, count1}, 32'd0);
    check("reset_cols1", {8'd0, cols1}, 32'd0);

    build_model();
    check("model_size", model.size(), 32'd92);

    // FIRST_ONLY instance with backpressure on its only solution.
    exp_q.delete();
    exp_q.push_back(24'h672BE0);
    @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    check("fo_busy_after_start", {31'd0, busy1}, 32'd1);
    cyc = 0;
    while (!valid1 && cyc < 20000) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("fo_valid_timeout", {31'd0, valid1}, 32'd1);
    check("fo_busy_in_emit", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_cols", {8'd0, cols1}, 32'h672BE0);
      check("bp_count", {25'd0, count1}, 32'd0);
      check("bp_valid", {31'd0, valid1}, 32'd1);
    end
    want = exp_q.pop_front();
    check("fo_transfer", {8'd0, cols1}, {8'd0, want});
    ready1 = 1'b1;
    @(posedge clk);
    #1;
    check("fo_count_after", {25'd0, count1}, 32'd1);
    check("fo_valid_drop", {31'd0, valid1}, 32'd0);
    check("fo_done", {31'd0, done1}, 32'd1);
    check("fo_busy_done", {31'd0, busy1}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("fo_done_held", {31'd0, done1}, 32'd1);
    check("fo_count_held", {25'd0, count1}, 32'd1);

    // Full search interrupted by reset after the 10th transfer.
    exp_q.delete();
    foreach (model[i]) exp_q.push_back(model[i]);
    @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 40000) begin
      if (valid0 && ready0) begin
        want = exp_q.pop_front();
        check("part_sol", {8'd0, cols0}, {8'd0, want});
        n++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    check("part_transfers", n, 32'd10);
    check("part_count", {25'd0, count0}, 32'd10);
    #2 rst = 1'b1;
    #1;
    check_zero0("mid_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    check_zero0("after_mid_rst");

    // Full search from a fresh start with start pulses injected while busy.
    exp_q.delete();
    foreach (model[i]) exp_q.push_back(model[i]);
    @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    check("full_busy", {31'd0, busy0}, 32'd1);
    check("full_count_start", {25'd0, count0}, 32'd0);
    n = 0;
    cyc = 0;
    last = 24'd0;
    while (!done0 && cyc < 150000) begin
      start0 = ((cyc % 4000) == 2000) && busy0;
      if (valid0 && ready0) begin
        got = cols0;
        if (n == 0) check("first_sol", {8'd0, got}, 32'h672BE0);
        check("count_track", {25'd0, count0}, n);
        check("non_attack", {31'd0, board_ok(got)}, 32'd1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check("sol_order", {8'd0, got}, {8'd0, want});
        end else begin
          check("extra_sol", 32'd1, 32'd0);
        end
        last = got;
        n++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start0 = 1'b0;
    check("full_timeout", {31'd0, done0}, 32'd1);
    check("full_busy_done", {31'd0, busy0}, 32'd0);
    check("full_transfers", n, 32'd92);
    check("full_count", {25'd0, count0}, 32'd92);
    check("last_sol", {8'd0, last}, 32'h98D41F);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("full_valid_low", {31'd0, valid0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
